fifo_pkt_reader: RTL and testbench

- Single-clock consumer on the read side of the team's show-ahead FIFOs (read port: data, empty, used words, read strobe).
- Pops words from the FIFO and emits them as framed packets on a valid/ready stream.
- A full packet is PKT_LEN words. A shorter packet is flushed when data sits too long or when flush_i is asserted.
- Used between a dc_fifo/sc_fifo read port and a packet-oriented sink.

---
 rtl/fifo_pkt_reader.sv | 140 ++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
// fifo_pkt_reader : drains a show-ahead FIFO read port into framed packets
//                   on a registered valid/ready stream (full, timeout, flush).
// Revision: 1.0
// ============================================================================
module fifo_pkt_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int WORDS_AMOUNT = 8,
    parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
    parameter int PKT_LEN      = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_used_words_i,
    output logic                  fifo_rd_o,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tvalid_o,
    input  logic                  tready_i,
    output logic                  tstart_o,
    output logic                  tlast_o,
    output logic                  busy_o
);

    localparam int CW       = ADDR_WIDTH + 1;
    localparam int TO_WIDTH = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0]       c_PKT_LEN = CW'(PKT_LEN);
    localparam logic [CW-1:0]       c_ONE     = CW'(1);
    localparam logic [TO_WIDTH-1:0] c_TO_LAST = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0] c_TO_ONE  = TO_WIDTH'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_next_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_len;
    logic [TO_WIDTH-1:0]   r_to_cnt;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tstart;
    logic                  r_tlast;

    logic                  w_accept;
    logic                  w_rd;
    logic                  w_busy;
    logic                  w_full;
    logic                  w_short;
    logic                  w_last_pop;
    logic [CW-1:0]         w_len_short;

    assign w_accept    = !r_tvalid || tready_i;
    assign w_full      = (fifo_used_words_i >= c_PKT_LEN);
    assign w_short     = !fifo_empty_i && (flush_i || (r_to_cnt == c_TO_LAST));
    assign w_last_pop  = w_rd && (r_cnt == (r_len - c_ONE));
    assign w_len_short = (fifo_used_words_i == '0) ? c_ONE : fifo_used_words_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_full || w_short) w_next_state = S_SEND;
            S_SEND:  if (w_last_pop)        w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd   = (r_state == S_SEND) && !fifo_empty_i && w_accept;
        w_busy = (r_state == S_SEND);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt    <= '0;
            r_len    <= '0;
            r_to_cnt <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (w_full) begin
                    r_len <= c_PKT_LEN;
                end else if (w_short) begin
                    r_len <= w_len_short;
                end
            end else if (w_rd) begin
                r_cnt <= w_last_pop ? '0 : r_cnt + c_ONE;
            end

            // Counts only while data waits in IDLE; cleared on empty or departure.
            if ((r_state == S_IDLE) && !fifo_empty_i && (w_next_state == S_IDLE)) begin
                if (r_to_cnt != c_TO_LAST) begin
                    r_to_cnt <= r_to_cnt + c_TO_ONE;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tstart <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_rd) begin
            r_tdata  <= fifo_data_i;
            r_tvalid <= 1'b1;
            r_tstart <= (r_cnt == '0);
            r_tlast  <= w_last_pop;
        end else if (tready_i) begin
            r_tvalid <= 1'b0;
            r_tstart <= 1'b0;
            r_tlast  <= 1'b0;
        end
    end

    assign fifo_rd_o = w_rd;
    assign busy_o    = w_busy;
    assign tdata_o   = r_tdata;
    assign tvalid_o  = r_tvalid;
    assign tstart_o  = r_tstart;
    assign tlast_o   = r_tlast;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
// tb_fifo_pkt_reader : directed bench with a show-ahead FIFO model feeding
//                      fifo_pkt_reader (PKT_LEN=4, TIMEOUT=16).
// Revision: 1.0
// ============================================================================
module tb_fifo_pkt_reader;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] fifo_data_i;
    logic       fifo_empty_i;
    logic [3:0] fifo_used_words_i;
    logic       fifo_rd_o;
    logic       flush_i;
    logic [7:0] tdata_o;
    logic       tvalid_o;
    logic       tready_i;
    logic       tstart_o;
    logic       tlast_o;
    logic       busy_o;

    fifo_pkt_reader #(
        .DATA_WIDTH(8), .WORDS_AMOUNT(8), .ADDR_WIDTH(3), .PKT_LEN(4), .TIMEOUT(16)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
        .fifo_used_words_i(fifo_used_words_i), .fifo_rd_o(fifo_rd_o),
        .flush_i(flush_i), .tdata_o(tdata_o), .tvalid_o(tvalid_o),
        .tready_i(tready_i), .tstart_o(tstart_o), .tlast_o(tlast_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       wr, rdy, fl, fe;
        logic       rd, v;
        logic [7:0] d;
        logic       s, l, b;
    } vec_t;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] q[$];
    logic       pend_pop = 1'b0;
    logic       pend_push = 1'b0;
    logic [7:0] pend_val = 8'h00;
    logic [7:0] next_val = 8'hA0;
    logic       force_e = 1'b0;
    logic [7:0] rx_d[$];
    logic       rx_s[$];
    logic       rx_l[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_fifo();
        fifo_empty_i      = force_e || (q.size() == 0);
        fifo_data_i       = (q.size() != 0) ? q[0] : 8'h00;
        fifo_used_words_i = 4'(q.size());
    endtask

    task automatic apply_pending();
        if (pend_pop && q.size() != 0) void'(q.pop_front());
        if (pend_push) q.push_back(pend_val);
        pend_pop  = 1'b0;
        pend_push = 1'b0;
    endtask

    // One clock cycle: commit last cycle's FIFO traffic, drive, settle, observe.
    task automatic cyc(input logic wr, input logic rdy, input logic fl, input logic fe);
        @(negedge clk_i);
        apply_pending();
        tready_i = rdy;
        flush_i  = fl;
        force_e  = fe;
        drive_fifo();
        #1;
        check("no_pop_when_empty", {63'd0, fifo_rd_o && fifo_empty_i}, 64'd0);
        if (tvalid_o && tready_i) begin
            rx_d.push_back(tdata_o);
            rx_s.push_back(tstart_o);
            rx_l.push_back(tlast_o);
        end
        pend_pop = fifo_rd_o;
        if (wr) begin
            pend_push = 1'b1;
            pend_val  = next_val;
            next_val  = next_val + 8'd1;
        end
    endtask

    task automatic clear_rx();
        rx_d.delete();
        rx_s.delete();
        rx_l.delete();
    endtask

    task automatic check_pkt(input string name, input logic [7:0] base, input int n);
        logic [9:0] act;
        logic [9:0] exp;
        check({name, "_len"}, 64'(rx_d.size()), 64'(n));
        for (int j = 0; j < n && j < rx_d.size(); j++) begin
            act = {rx_s[j], rx_l[j], rx_d[j]};
            exp = {(j == 0), (j == n - 1), 8'(base + 8'(j))};
            check($sformatf("%s_word%0d", name, j), 64'(act), 64'(exp));
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rdy, input logic fl, input logic fe,
                                input logic rd, input logic v, input logic [7:0] d,
                                input logic s, input logic l, input logic b);
        vec_t r;
        r = '{wr: wr, rdy: rdy, fl: fl, fe: fe, rd: rd, v: v, d: d, s: s, l: l, b: b};
        return r;
    endfunction

    initial begin
        vec_t       tbl[17];
        logic [7:0] base;
        logic [7:0] prev_d;
        logic       prev_stall;
        int         gap;
        int         first_gap;
        logic       started;
        int         guard;

        // 4-word full packet, then 1-word flush and a flush on an empty FIFO
        tbl[0]  = mk(1,1,0,0, 0,0,8'h00,0,0,0);
        tbl[1]  = mk(1,1,0,0, 0,0,8'h00,0,0,0);
        tbl[2]  = mk(1,1,0,0, 0,0,8'h00,0,0,0);
        tbl[3]  = mk(1,1,0,0, 0,0,8'h00,0,0,0);
        tbl[4]  = mk(0,1,0,0, 0,0,8'h00,0,0,0);
        tbl[5]  = mk(0,1,0,0, 1,0,8'h00,0,0,1);
        tbl[6]  = mk(0,1,0,0, 1,1,8'hA0,1,0,1);
        tbl[7]  = mk(0,1,0,0, 1,1,8'hA1,0,0,1);
        tbl[8]  = mk(0,1,0,0, 1,1,8'hA2,0,0,1);
        tbl[9]  = mk(0,1,0,0, 0,1,8'hA3,0,1,0);
        tbl[10] = mk(0,1,0,0, 0,0,8'h00,0,0,0);
        tbl[11] = mk(1,1,0,0, 0,0,8'h00,0,0,0);
        tbl[12] = mk(0,1,1,0, 0,0,8'h00,0,0,0);
        tbl[13] = mk(0,1,0,0, 1,0,8'h00,0,0,1);
        tbl[14] = mk(0,1,0,0, 0,1,8'hA4,1,1,0);
        tbl[15] = mk(0,1,1,0, 0,0,8'h00,0,0,0);
        tbl[16] = mk(0,1,0,0, 0,0,8'h00,0,0,0);

        rst_n_i  = 1'b0;
        tready_i = 1'b0;
        flush_i  = 1'b0;
        drive_fifo();
        #12;
        check("reset_outputs", {58'd0, tvalid_o, tstart_o, tlast_o, fifo_rd_o, busy_o, |tdata_o}, 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].wr, tbl[i].rdy, tbl[i].fl, tbl[i].fe);
            check($sformatf("vec%0d", i),
                  64'({fifo_rd_o, tvalid_o, (tbl[i].v ? tdata_o : 8'h00), tstart_o, tlast_o, busy_o}),
                  64'({tbl[i].rd, tbl[i].v, (tbl[i].v ? tbl[i].d : 8'h00), tbl[i].s, tbl[i].l, tbl[i].b}));
        end

        // 8 words with tready toggling: two packets, holds while stalled, one IDLE gap
        clear_rx();
        base       = next_val;
        prev_stall = 1'b0;
        prev_d     = 8'h00;
        started    = 1'b0;
        gap        = 0;
        first_gap  = -1;
        for (int i = 0; i < 30; i++) begin
            cyc(i < 8, (i % 2) == 0, 1'b0, 1'b0);
            if (prev_stall) check("stall_hold", 64'({tvalid_o, tdata_o}), 64'({1'b1, prev_d}));
            prev_stall = tvalid_o && !tready_i;
            prev_d     = tdata_o;
            if (busy_o) begin
                if (started && gap > 0 && first_gap < 0) first_gap = gap;
                started = 1'b1;
                gap     = 0;
            end else if (started) begin
                gap++;
            end
        end
        check("idle_gap", 64'(first_gap), 64'd1);
        check("toggle_count", 64'(rx_d.size()), 64'd8);
        for (int j = 0; j < 8 && j < rx_d.size(); j++) begin
            check($sformatf("toggle_word%0d", j),
                  64'({rx_s[j], rx_l[j], rx_d[j]}),
                  64'({(j % 4) == 0, (j % 4) == 3, 8'(base + 8'(j))}));
        end

        // 2 words, no flush: nothing until the timeout expires
        clear_rx();
        base = next_val;
        for (int j = 0; j < 17; j++) begin
            cyc(j < 2, 1'b1, 1'b0, 1'b0);
            check($sformatf("timeout_wait%0d", j), 64'({busy_o, tvalid_o}), 64'd0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("timeout_fire", 64'(busy_o), 64'd1);
        for (int j = 0; j < 4; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check_pkt("timeout_pkt", base, 2);

        // Reset in the middle of a packet
        clear_rx();
        guard = 0;
        while (rx_d.size() < 2 && guard < 20) begin
            cyc(guard < 4, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check("pre_reset_words", 64'(rx_d.size()), 64'd2);
        @(negedge clk_i);
        apply_pending();
        q.delete();
        rst_n_i = 1'b0;
        drive_fifo();
        #1;
        check("mid_reset_outputs", {58'd0, tvalid_o, tstart_o, tlast_o, fifo_rd_o, busy_o, |tdata_o}, 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        clear_rx();
        base = next_val;
        for (int j = 0; j < 15; j++) cyc(j < 4, 1'b1, 1'b0, 1'b0);
        check_pkt("post_reset_pkt", base, 4);

        // FIFO goes empty for 5 cycles mid-packet
        clear_rx();
        base = next_val;
        for (int j = 0; j < 22; j++) begin
            cyc(j < 4, 1'b1, 1'b0, (j >= 6) && (j <= 10));
            if ((j >= 6) && (j <= 10))
                check($sformatf("empty_stall%0d", j), 64'({fifo_rd_o, busy_o}), 64'b01);
        end
        check_pkt("empty_stall_pkt", base, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
